// File: rtl/gam_assoc_scheduler_pkg.sv
// Shared types for the GAM associative-layer scheduler: node/class widths,
// the buffered training-pair payload and the sequencing FSM states.
package GAM_package;

  localparam int unsigned GAM_NODE_W      = 64;
  localparam int unsigned GAM_NUM_CLASSES = 16;
  localparam int unsigned GAM_CLS_W       = $clog2(GAM_NUM_CLASSES);

  typedef logic [GAM_NODE_W-1:0] node_vector_T;
  typedef logic [GAM_CLS_W-1:0]  class_idx_T;

  typedef struct packed {
    node_vector_T key_x;
    class_idx_T   key_c;
    node_vector_T resp_x;
    class_idx_T   resp_c;
  } assoc_pair_T;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_KEY_ISSUE  = 3'd1,
    S_KEY_WAIT   = 3'd2,
    S_RESP_ISSUE = 3'd3,
    S_RESP_WAIT  = 3'd4,
    S_POP        = 3'd5
  } assoc_sched_state_T;

  function automatic logic class_ok(input int unsigned cls, input int unsigned num);
    return cls < num;
  endfunction

endpackage

// File: rtl/gam_assoc_scheduler_fifo.sv
// Synchronous FIFO of training pairs with registered full/empty flags.
module gam_pair_fifo
  import GAM_package::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  assoc_pair_T data_i,
  input  logic        pop_i,
  output assoc_pair_T data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  assoc_pair_T      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push = push_i && !full_q;
    do_pop  = pop_i && !empty_q;
    cnt_d   = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/gam_assoc_scheduler.sv
// Replays buffered (key, response) training pairs to the associative layer
// as a key phase then a response phase, with timeouts and class checks.
module gam_assoc_scheduler
  import GAM_package::*;
#(
  parameter int unsigned NODE_W      = GAM_NODE_W,
  parameter int unsigned NUM_CLASSES = GAM_NUM_CLASSES,
  parameter int unsigned CLS_W       = $clog2(NUM_CLASSES),
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pair_valid_i,
  output logic              pair_ready_o,
  input  logic [NODE_W-1:0] key_x_i,
  input  logic [CLS_W-1:0]  key_c_i,
  input  logic [NODE_W-1:0] resp_x_i,
  input  logic [CLS_W-1:0]  resp_c_i,
  output logic [NODE_W-1:0] al_x_o,
  output logic [CLS_W-1:0]  al_c_o,
  output logic              al_key_response_o,
  output logic              al_start_o,
  input  logic              al_done_i,
  input  logic              err_clr_i,
  output logic              busy_o,
  output logic [15:0]       pair_count_o,
  output logic              timeout_err_o,
  output logic              class_err_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  assoc_sched_state_T state_q;
  logic [TO_W-1:0]    tmo_q;
  logic               drop_q;
  logic [NODE_W-1:0]  al_x_q;
  logic [CLS_W-1:0]   al_c_q;
  logic               al_kr_q;
  logic               al_start_q;
  logic [15:0]        pair_count_q;
  logic               timeout_err_q;
  logic               class_err_q;

  assoc_pair_T fifo_wdata;
  assoc_pair_T fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        class_bad;
  logic        class_set;
  logic        push;
  logic        pop;
  logic        in_wait;
  logic        tmo_hit;
  logic        timeout_set;

  always_comb begin
    class_bad   = !class_ok(32'(key_c_i), NUM_CLASSES) ||
                  !class_ok(32'(resp_c_i), NUM_CLASSES);
    accept      = pair_valid_i && !fifo_full;
    push        = accept && !class_bad;
    class_set   = accept && class_bad;
    pop         = (state_q == S_POP);
    in_wait     = (state_q == S_KEY_WAIT) || (state_q == S_RESP_WAIT);
    tmo_hit     = (tmo_q == TO_W'(TIMEOUT - 1));
    timeout_set = in_wait && !al_done_i && tmo_hit;
    fifo_wdata        = '0;
    fifo_wdata.key_x  = node_vector_T'(key_x_i);
    fifo_wdata.key_c  = class_idx_T'(key_c_i);
    fifo_wdata.resp_x = node_vector_T'(resp_x_i);
    fifo_wdata.resp_c = class_idx_T'(resp_c_i);
  end

  gam_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequencer; al_* are loaded on entry to each ISSUE state and held otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      drop_q        <= 1'b0;
      al_x_q        <= '0;
      al_c_q        <= '0;
      al_kr_q       <= 1'b0;
      al_start_q    <= 1'b0;
      pair_count_q  <= '0;
      timeout_err_q <= 1'b0;
      class_err_q   <= 1'b0;
    end else begin
      al_start_q    <= 1'b0;
      timeout_err_q <= timeout_set || (timeout_err_q && !err_clr_i);
      class_err_q   <= class_set || (class_err_q && !err_clr_i);
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_q    <= S_KEY_ISSUE;
            al_x_q     <= NODE_W'(fifo_head.key_x);
            al_c_q     <= CLS_W'(fifo_head.key_c);
            al_kr_q    <= 1'b0;
            al_start_q <= 1'b1;
            drop_q     <= 1'b0;
          end
        end
        S_KEY_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_KEY_WAIT;
        end
        S_KEY_WAIT: begin
          if (al_done_i) begin
            state_q    <= S_RESP_ISSUE;
            al_x_q     <= NODE_W'(fifo_head.resp_x);
            al_c_q     <= CLS_W'(fifo_head.resp_c);
            al_kr_q    <= 1'b1;
            al_start_q <= 1'b1;
          end else if (tmo_hit) begin
            state_q <= S_POP;
            drop_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TO_W'(1);
          end
        end
        S_RESP_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_RESP_WAIT;
        end
        S_RESP_WAIT: begin
          if (al_done_i) begin
            state_q <= S_POP;
          end else if (tmo_hit) begin
            state_q <= S_POP;
            drop_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TO_W'(1);
          end
        end
        S_POP: begin
          if (!drop_q) pair_count_q <= pair_count_q + 16'd1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pair_ready_o      = !fifo_full;
  assign busy_o            = (state_q != S_IDLE) || !fifo_empty;
  assign al_x_o            = al_x_q;
  assign al_c_o            = al_c_q;
  assign al_key_response_o = al_kr_q;
  assign al_start_o        = al_start_q;
  assign pair_count_o      = pair_count_q;
  assign timeout_err_o     = timeout_err_q;
  assign class_err_o       = class_err_q;

endmodule

// File: tb/tb_gam_assoc_scheduler.sv
// Directed bench for gam_assoc_scheduler; class width widened to 5 bits so
// out-of-range class indices can be offered.
module tb_gam_assoc_scheduler;

  localparam int unsigned NODE_W = 64;
  localparam int unsigned CLS_W  = 5;

  logic              clk;
  logic              rst;
  logic              pair_valid;
  logic              pair_ready;
  logic [NODE_W-1:0] key_x;
  logic [CLS_W-1:0]  key_c;
  logic [NODE_W-1:0] resp_x;
  logic [CLS_W-1:0]  resp_c;
  logic [NODE_W-1:0] al_x;
  logic [CLS_W-1:0]  al_c;
  logic              al_kr;
  logic              al_start;
  logic              al_done;
  logic              err_clr;
  logic              busy;
  logic [15:0]       pair_count;
  logic              timeout_err;
  logic              class_err;

  int checks = 0;
  int errors = 0;
  int n_starts = 0;

  gam_assoc_scheduler #(
    .NODE_W      (NODE_W),
    .NUM_CLASSES (16),
    .CLS_W       (CLS_W),
    .FIFO_DEPTH  (4),
    .TIMEOUT     (255)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .pair_valid_i      (pair_valid),
    .pair_ready_o      (pair_ready),
    .key_x_i           (key_x),
    .key_c_i           (key_c),
    .resp_x_i          (resp_x),
    .resp_c_i          (resp_c),
    .al_x_o            (al_x),
    .al_c_o            (al_c),
    .al_key_response_o (al_kr),
    .al_start_o        (al_start),
    .al_done_i         (al_done),
    .err_clr_i         (err_clr),
    .busy_o            (busy),
    .pair_count_o      (pair_count),
    .timeout_err_o     (timeout_err),
    .class_err_o       (class_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (al_start === 1'b1) n_starts <= n_starts + 1;

  function automatic logic [63:0] kx(input int c);
    return 64'hA5A5_0000_0000_0000 | 64'(c);
  endfunction

  function automatic logic [63:0] rx(input int c);
    return 64'h5A5A_0000_0000_0000 | 64'(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input int kc, input int rc);
    pair_valid = 1'b1;
    key_c  = 5'(kc);
    key_x  = kx(kc);
    resp_c = 5'(rc);
    resp_x = rx(rc);
    tick();
    pair_valid = 1'b0;
  endtask

  // Waits (bounded) for the key-phase start and checks its payload.
  task automatic wait_key_start(input int kc);
    for (int i = 0; i < 20; i++) begin
      if (al_start === 1'b1) break;
      tick();
    end
    check("key_start", 64'(al_start), 64'(1));
    check("key_kr", 64'(al_kr), 64'(0));
    check("key_c", 64'(al_c), 64'(kc));
    check("key_x", al_x, kx(kc));
  endtask

  // From KEY_WAIT: answer both phases in their first wait cycle.
  task automatic serve_from_kw(input int rc);
    al_done = 1'b1;
    tick();
    al_done = 1'b0;
    check("resp_start", 64'(al_start), 64'(1));
    check("resp_kr", 64'(al_kr), 64'(1));
    check("resp_c", 64'(al_c), 64'(rc));
    check("resp_x", al_x, rx(rc));
    tick();
    al_done = 1'b1;
    tick();
    al_done = 1'b0;
    tick();
  endtask

  task automatic serve(input int kc, input int rc);
    wait_key_start(kc);
    tick();
    serve_from_kw(rc);
  endtask

  initial begin
    rst = 1'b1; pair_valid = 1'b0; key_x = '0; key_c = '0;
    resp_x = '0; resp_c = '0; al_done = 1'b0; err_clr = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_ready", 64'(pair_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_start", 64'(al_start), 64'(0));
    check("rst_count", 64'(pair_count), 64'(0));
    check("rst_errs", 64'({timeout_err, class_err}), 64'(0));
    check("rst_al", 64'({al_x, al_c, al_kr}), 64'(0));
    rst = 1'b0;
    tick();

    // Single pair: start one cycle after the accepting edge, 5 cycles to IDLE
    offer(3, 7);
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_nostart", 64'(al_start), 64'(0));
    tick();
    check("t1_latency", 64'(al_start), 64'(1));
    serve(3, 7);
    check("t1_count", 64'(pair_count), 64'(1));
    check("t1_idle", 64'(busy), 64'(0));
    check("t1_starts", 64'(n_starts), 64'(2));

    // Five pairs with the layer stalled: fifth refused, order preserved
    offer(1, 9);
    check("t2_ready1", 64'(pair_ready), 64'(1));
    offer(2, 10);
    check("t2_first_key", 64'({al_start, al_c}), 64'({1'b1, 5'd1}));
    offer(3, 11);
    offer(4, 12);
    check("t2_full", 64'(pair_ready), 64'(0));
    pair_valid = 1'b1; key_c = 5'd5; key_x = kx(5); resp_c = 5'd13; resp_x = rx(13);
    tick();
    check("t2_refused", 64'(pair_ready), 64'(0));
    tick();
    pair_valid = 1'b0;
    serve_from_kw(9);
    check("t2_ready_after_pop", 64'(pair_ready), 64'(1));
    serve(2, 10);
    serve(3, 11);
    serve(4, 12);
    check("t2_count4", 64'(pair_count), 64'(5));
    check("t2_idle", 64'(busy), 64'(0));
    offer(5, 13);
    serve(5, 13);
    check("t2_count5", 64'(pair_count), 64'(6));
    check("t2_starts", 64'(n_starts), 64'(12));

    // Key-phase timeout after 255 wait cycles, pair dropped
    offer(2, 9);
    wait_key_start(2);
    tick();
    repeat (254) tick();
    check("t3_not_yet", 64'(timeout_err), 64'(0));
    tick();
    check("t3_timeout", 64'(timeout_err), 64'(1));
    check("t3_no_resp", 64'({al_start, al_kr}), 64'(0));
    tick();
    check("t3_count", 64'(pair_count), 64'(6));
    check("t3_idle", 64'(busy), 64'(0));
    check("t3_starts", 64'(n_starts), 64'(13));
    offer(4, 11);
    serve(4, 11);
    check("t3_next_count", 64'(pair_count), 64'(7));
    check("t3_sticky", 64'(timeout_err), 64'(1));

    // Out-of-range response class: accepted, not stored
    offer(1, 16);
    check("t4_class_err", 64'(class_err), 64'(1));
    check("t4_not_stored", 64'(busy), 64'(0));
    check("t4_ready", 64'(pair_ready), 64'(1));
    repeat (3) tick();
    check("t4_starts", 64'(n_starts), 64'(15));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_clr", 64'({timeout_err, class_err}), 64'(0));
    err_clr = 1'b1;
    offer(20, 0);
    err_clr = 1'b0;
    check("t4_set_wins", 64'(class_err), 64'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_clr2", 64'(class_err), 64'(0));

    // al_done in IDLE and KEY_ISSUE is ignored
    al_done = 1'b1;
    tick();
    al_done = 1'b0;
    check("t5_idle_done", 64'({busy, pair_count}), 64'({1'b0, 16'd7}));
    offer(6, 14);
    al_done = 1'b1;
    tick();
    check("t5_in_issue", 64'(al_start), 64'(1));
    tick();
    al_done = 1'b0;
    check("t5_kw", 64'({al_start, al_kr}), 64'(0));
    tick(); tick();
    check("t5_still_kw", 64'({al_start, al_kr, al_c}), 64'({2'b00, 5'd6}));
    serve_from_kw(14);
    check("t5_count", 64'(pair_count), 64'(8));
    check("t5_starts", 64'(n_starts), 64'(17));

    // Reset during RESP_WAIT with more pairs queued
    offer(7, 15);
    offer(8, 1);
    offer(9, 2);
    offer(0, 31);
    check("t6_class_err", 64'(class_err), 64'(1));
    al_done = 1'b1;
    tick();
    al_done = 1'b0;
    tick();
    check("t6_in_rw", 64'({al_kr, al_c}), 64'({1'b1, 5'd15}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_ready", 64'(pair_ready), 64'(1));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_count", 64'(pair_count), 64'(0));
    check("t6_errs", 64'({timeout_err, class_err}), 64'(0));
    check("t6_al", 64'({al_x, al_c, al_kr, al_start}), 64'(0));
    repeat (5) tick();
    check("t6_no_start", 64'(n_starts), 64'(19));
    check("t6_quiet", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
